trng_sample_ctrl: RTL
=====================

# trng_sample_ctrl

Controller that sequences the ring-oscillator entropy source of the TRNG. It enables the oscillator, waits a warm-up period, then samples the asynchronous raw bit at a programmable rate. It runs a repetition-count health test on the raw samples, applies von Neumann debiasing, and packs the debiased bits into bytes. Bytes leave through a valid/ready handshake. The block sits between the free-running `ring_oscillator` instance and the top-level output pins.

## Interface
Parameters:
- `WARMUP_CYCLES`, default 64: clock cycles with `ro_en`=1 before any sample is used (≥1).
- `SAMPLE_DIV`, default 4: clock cycles per raw sample (≥2).
- `REP_LIMIT`, default 16: number of consecutive identical raw samples that declares a fault (≥2).

Ports:
- `clk` input 1: single clock. All state is on its rising edge.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `start` input 1: level/pulse. Begins a run when sampled high in IDLE.
- `stop` input 1: aborts a run, or clears FAULT. Has priority over `start`.
- `ro_bit` input 1: raw oscillator output, asynchronous to `clk`.
- `ro_en` output 1: oscillator enable.
- `byte_out` output 8: packed random byte. Bit 0 is the first debiased bit.
- `byte_valid` output 1: `byte_out` holds an unconsumed byte.
- `byte_ready` input 1: consumer accepts the byte when `byte_valid` and `byte_ready` are both high at a rising edge.
- `health_fail` output 1: repetition-count fault latched.
- `state_out` output 2: IDLE=0, WARMUP=1, RUN=2, FAULT=3.

## Operation
- `ro_bit` passes through a 2-flop synchronizer, which is always clocked. The synchronized value is the "raw sample" source.
- States and transitions. All transitions are registered and take effect the next cycle.
  - IDLE: if `stop`, stay in IDLE. Else if `start`, go to WARMUP.
  - WARMUP: if `stop`, go to IDLE. Else after `WARMUP_CYCLES` cycles in WARMUP, go to RUN.
  - RUN: if `stop`, go to IDLE. Else if a repetition fault occurs, go to FAULT.
  - FAULT: if `stop`, go to IDLE. `start` is ignored.
- `ro_en` is 1 in WARMUP and RUN, 0 in IDLE and FAULT.
- Sample divider:
  - Counts 0..`SAMPLE_DIV`-1 and is cleared on entry to RUN.
  - A sample tick occurs in RUN when the count equals `SAMPLE_DIV`-1.
  - No ticks occur outside RUN.
- Repetition test:
  - A counter of consecutive equal raw samples is reset on RUN entry.
  - The first sample sets the count to 1. An equal sample increments it; a different sample resets it to 1.
  - When the count reaches `REP_LIMIT`, the state goes to FAULT and `health_fail` is set.
  - The debiased bit from the triggering sample is discarded.
- Von Neumann debiasing:
  - A pair phase is reset on RUN entry.
  - Samples pair as (a, b). If a≠b, emit a. Pairs 00 and 11 emit nothing.
- Packer:
  - An 8-bit shift register with a 0–8 bit count, shifted LSB-first.
  - When the count reaches 8 and the output register is free, the byte transfers and the count becomes 0.
  - The output register is free when `byte_valid`=0, or when a handshake completes in the same cycle.
  - While the packer holds 8 bits and the output register is occupied, further debiased bits are dropped.
- Output register:
  - Loaded only from the packer.
  - `byte_out` is stable while `byte_valid`=1 and no handshake has occurred.
- `stop` from WARMUP/RUN clears the packer and pair phase. A byte already in the output register is retained until consumed.
- Entry to FAULT clears the packer and `byte_valid`, because data is tainted.
- Leaving FAULT via `stop` clears `health_fail`.

## Timing
- Reset values: state IDLE, `ro_en`=0, `byte_out`=0x00, `byte_valid`=0, `health_fail`=0, `state_out`=0. All counters, the packer, and the synchronizer are 0.
- `start` high at edge N gives WARMUP and `ro_en`=1 after edge N. RUN is reached after edge N+`WARMUP_CYCLES`.
- Latency of `ro_bit` to a sample: 2 synchronizer cycles plus alignment to the divider tick.
- The last bit of a byte is shifted in at tick edge T. `byte_valid`=1 after edge T+1 if the output register is free.
- Throughput with `byte_ready` held high: one byte per 8 accepted debiased bits, with no bubble.
- Fault: the `REP_LIMIT`-th equal sample tick at edge T gives, after edge T+1, `health_fail`=1, `ro_en`=0, `byte_valid`=0, and `state_out`=3.
- Simultaneous `start` and `stop` in IDLE: stay in IDLE.
- A handshake in the same cycle as a `stop` completes normally.

## Test plan
All scenarios use `WARMUP_CYCLES`=4, `SAMPLE_DIV`=2, `REP_LIMIT`=8. The bench drives `ro_bit` synchronously, pre-compensating the 2-cycle synchronizer.
1. Assert `rst_n`=0 mid-run (asynchronous). Required: all outputs at their reset values immediately, with no clock edge.
2. Pulse `start`. Required: `ro_en`=1 and `state_out`=1 on the next cycle; `state_out`=2 exactly 4 cycles later; no sample ticks during WARMUP.
3. In RUN, drive raw pairs 10,01,11,10,01,01,00,10,01,10. Pairs 11 and 00 must be discarded. Required: a single byte `byte_out`=0xA5 with `byte_valid`=1 one cycle after the last tick.
4. Hold `byte_ready`=0 across two byte completions (0xA5, then 0x3C), with extra pairs after that. Required:
   - 0xA5 stays stable.
   - On the first accept, 0x3C appears the next cycle with no gap.
   - Bits arriving while both registers are full are dropped.
5. Hold `ro_bit`=1 in RUN. Required:
   - After the 8th sample: `health_fail`=1, `ro_en`=0, `byte_valid`=0, `state_out`=3.
   - `start` is ignored in FAULT.
   - `stop` gives IDLE with `health_fail`=0.
6. Assert `stop` after 5 debiased bits. Required: IDLE and `ro_en`=0 next cycle. The next run must produce its first byte from 8 fresh bits, with no stale bits carried over.

Source files
------------

// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl: sequences the ring-oscillator entropy source.
// Enables the oscillator, waits out warm-up, samples the synchronized raw
// bit at a fixed divider rate, runs a repetition-count health test, applies
// von Neumann debiasing and packs the surviving bits LSB-first into bytes
// that leave through a valid/ready output register.
module trng_sample_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       ro_bit,
  output logic       ro_en,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       health_fail,
  output logic [1:0] state_out
);

  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t            state;
  logic              sync_meta;
  logic              raw;
  logic [WARM_W-1:0] warm_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              last_sample;
  logic              pair_phase;
  logic              pair_first;
  logic [7:0]        pack_sr;
  logic [3:0]        pack_cnt;

  logic              run_entry;
  logic              fault_entry;
  logic              abort;
  logic              tick;
  logic              emit;
  logic              handshake;
  logic              out_free;
  logic              pack_full;
  logic              transfer;
  logic [REP_W-1:0]  rep_next;

  assign state_out = state;

  // Decode the per-cycle events that steer the sampling datapath and packer.
  // The triggering sample of a repetition fault never contributes a bit.
  always_comb begin
    run_entry   = (state == WARMUP) && !stop && (warm_cnt == WARM_LAST);
    fault_entry = (state == RUN) && !stop && (rep_cnt == REP_MAX);
    abort       = stop && ((state == WARMUP) || (state == RUN));
    tick        = (state == RUN) && !stop && (div_cnt == DIV_LAST);
    rep_next    = ((rep_cnt == '0) || (raw != last_sample)) ? REP_W'(1)
                                                            : rep_cnt + REP_W'(1);
    emit        = tick && pair_phase && (pair_first != raw) && (rep_next != REP_MAX);
    handshake   = byte_valid && byte_ready;
    out_free    = !byte_valid || byte_ready;
    pack_full   = (pack_cnt == 4'd8);
    transfer    = pack_full && out_free && !abort && !fault_entry;
  end

  // Two-flop synchronizer for the asynchronous oscillator bit, always clocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      raw       <= 1'b0;
    end else begin
      sync_meta <= ro_bit;
      raw       <= sync_meta;
    end
  end

  // Run-control FSM with registered oscillator enable and fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      warm_cnt    <= '0;
      ro_en       <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            ro_en    <= 1'b1;
          end
        end
        WARMUP: begin
          if (stop) begin
            state <= IDLE;
            ro_en <= 1'b0;
          end else if (warm_cnt == WARM_LAST) begin
            state <= RUN;
          end else begin
            warm_cnt <= warm_cnt + WARM_W'(1);
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            ro_en <= 1'b0;
          end else if (rep_cnt == REP_MAX) begin
            state       <= FAULT;
            ro_en       <= 1'b0;
            health_fail <= 1'b1;
          end
        end
        FAULT: begin
          if (stop) begin
            state       <= IDLE;
            health_fail <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ro_en <= 1'b0;
        end
      endcase
    end
  end

  // Sample divider, repetition counter and von Neumann pair tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      rep_cnt     <= '0;
      last_sample <= 1'b0;
      pair_phase  <= 1'b0;
      pair_first  <= 1'b0;
    end else if (run_entry) begin
      div_cnt    <= '0;
      rep_cnt    <= '0;
      pair_phase <= 1'b0;
    end else if (abort) begin
      pair_phase <= 1'b0;
    end else if (state == RUN) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        rep_cnt     <= rep_next;
        last_sample <= raw;
        if (pair_phase) begin
          pair_phase <= 1'b0;
        end else begin
          pair_phase <= 1'b1;
          pair_first <= raw;
        end
      end
    end
  end

  // LSB-first packer; a bit arriving on the edge that empties it starts the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_sr  <= 8'h00;
      pack_cnt <= 4'd0;
    end else if (abort || fault_entry) begin
      pack_sr  <= 8'h00;
      pack_cnt <= 4'd0;
    end else if (transfer) begin
      if (emit) begin
        pack_sr  <= {pair_first, 7'b0};
        pack_cnt <= 4'd1;
      end else begin
        pack_sr  <= 8'h00;
        pack_cnt <= 4'd0;
      end
    end else if (emit && !pack_full) begin
      pack_sr  <= {pair_first, pack_sr[7:1]};
      pack_cnt <= pack_cnt + 4'd1;
    end
  end

  // Output register: loaded only from the packer, dropped on a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
    end else if (fault_entry) begin
      byte_valid <= 1'b0;
    end else if (transfer) begin
      byte_out   <= pack_sr;
      byte_valid <= 1'b1;
    end else if (handshake) begin
      byte_valid <= 1'b0;
    end
  end

endmodule
